// File: rtl/hero_controller.sv
// Character movement, bomb fuse and blast/rescue detection for the hero game.
// Movement runs a 4-state pass per frame so the renderer's collision flag can settle.
module hero_controller #(
   parameter int START_X     = 282,
   parameter int START_Y     = 30,
   parameter int STEP_X      = 2,
   parameter int STEP_UP     = 2,
   parameter int GRAVITY     = 1,
   parameter int FUSE_FRAMES = 32,
   parameter int BOMBS       = 6,
   parameter int BLAST_R     = 40
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       active,
   input  logic       frame_tick,
   input  logic       key_left,
   input  logic       key_right,
   input  logic       key_up,
   input  logic       f_key,
   input  logic       coll,
   input  logic       coll_miner,
   output logic [9:0] char_pos_x,
   output logic [9:0] char_pos_y,
   output logic [9:0] bomb_pos_x,
   output logic [9:0] bomb_pos_y,
   output logic [3:0] b_cnt,
   output logic [2:0] bombs_left,
   output logic       level_done,
   output logic       death
);

   typedef enum logic [1:0] {IDLE, MOVE, SETTLE, CHECK} state_t;

   localparam int FUSE_W = $clog2(FUSE_FRAMES + 1);
   localparam logic [FUSE_W-1:0] FUSE_LAST = FUSE_W'(FUSE_FRAMES - 1);

   localparam logic signed [11:0] STEP_X_S  = 12'(STEP_X);
   localparam logic signed [11:0] STEP_UP_S = 12'(STEP_UP);
   localparam logic signed [11:0] GRAVITY_S = 12'(GRAVITY);
   localparam logic signed [11:0] X_MIN_S   = 12'sd14;
   localparam logic signed [11:0] X_MAX_S   = 12'sd625;
   localparam logic signed [11:0] Y_MIN_S   = 12'sd29;
   localparam logic signed [11:0] Y_MAX_S   = 12'sd450;
   localparam logic signed [10:0] BLAST_S   = 11'(BLAST_R);

   state_t            state_q, state_d;
   logic [9:0]        char_x_q, char_x_d, char_y_q, char_y_d;
   logic [9:0]        good_x_q, good_x_d, good_y_q, good_y_d;
   logic [9:0]        bomb_x_q, bomb_x_d, bomb_y_q, bomb_y_d;
   logic [1:0]        b_cnt_q, b_cnt_d;
   logic [2:0]        bombs_q, bombs_d;
   logic [FUSE_W-1:0] fuse_q, fuse_d;
   logic              level_done_q, level_done_d;
   logic              death_q, death_d;
   logic              f_key_q, f_key_d;

   logic              drop;
   logic signed [11:0] nx, ny;

   // Clamp keeps the renderer's unsigned edge arithmetic from wrapping.
   function automatic logic [9:0] sat_pos(input logic signed [11:0] v,
                                          input logic signed [11:0] lo,
                                          input logic signed [11:0] hi);
      logic signed [11:0] r;
      if (v < lo)      r = lo;
      else if (v > hi) r = hi;
      else             r = v;
      return r[9:0];
   endfunction

   function automatic logic in_blast(input logic [9:0] a, input logic [9:0] b);
      logic signed [10:0] diff;
      diff = $signed({1'b0, a}) - $signed({1'b0, b});
      if (diff[10]) diff = -diff;
      return diff < BLAST_S;
   endfunction

   always_comb begin
      state_d      = state_q;
      char_x_d     = char_x_q;
      char_y_d     = char_y_q;
      good_x_d     = good_x_q;
      good_y_d     = good_y_q;
      bomb_x_d     = bomb_x_q;
      bomb_y_d     = bomb_y_q;
      b_cnt_d      = b_cnt_q;
      bombs_d      = bombs_q;
      fuse_d       = fuse_q;
      level_done_d = level_done_q;
      death_d      = death_q;
      f_key_d      = f_key;
      drop         = 1'b0;

      nx = $signed({2'b00, char_x_q});
      if (key_left && !key_right)      nx = nx - STEP_X_S;
      else if (key_right && !key_left) nx = nx + STEP_X_S;
      ny = $signed({2'b00, char_y_q});
      if (key_up) ny = ny - STEP_UP_S;
      else        ny = ny + GRAVITY_S;

      if (!active) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (frame_tick && !death_q && !level_done_q) begin
                  state_d  = MOVE;
                  good_x_d = char_x_q;
                  good_y_d = char_y_q;
               end
            end
            MOVE: begin
               char_x_d = sat_pos(nx, X_MIN_S, X_MAX_S);
               char_y_d = sat_pos(ny, Y_MIN_S, Y_MAX_S);
               state_d  = SETTLE;
            end
            SETTLE: state_d = CHECK;
            CHECK: begin
               if (coll) begin
                  char_x_d = good_x_q;
                  char_y_d = good_y_q;
               end
               if (coll_miner) level_done_d = 1'b1;
               state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase

         // A fresh drop wins over a same-cycle tick so the new fuse starts at zero.
         drop = f_key && !f_key_q && (b_cnt_q == 2'd0) && (bombs_q != 3'd0);
         if (drop) begin
            bomb_x_d = char_x_q;
            bomb_y_d = char_y_q + 10'd18;
            b_cnt_d  = 2'd1;
            fuse_d   = '0;
            bombs_d  = bombs_q - 3'd1;
         end else if ((b_cnt_q != 2'd0) && frame_tick) begin
            if (fuse_q == FUSE_LAST) begin
               fuse_d  = '0;
               b_cnt_d = b_cnt_q + 2'd1;
               if ((b_cnt_q == 2'd2) && in_blast(char_x_q, bomb_x_q) && in_blast(char_y_q, bomb_y_q))
                  death_d = 1'b1;
            end else begin
               fuse_d = fuse_q + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         char_x_q     <= 10'(START_X);
         char_y_q     <= 10'(START_Y);
         good_x_q     <= 10'(START_X);
         good_y_q     <= 10'(START_Y);
         bomb_x_q     <= '0;
         bomb_y_q     <= '0;
         b_cnt_q      <= '0;
         bombs_q      <= 3'(BOMBS);
         fuse_q       <= '0;
         level_done_q <= 1'b0;
         death_q      <= 1'b0;
         f_key_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         char_x_q     <= char_x_d;
         char_y_q     <= char_y_d;
         good_x_q     <= good_x_d;
         good_y_q     <= good_y_d;
         bomb_x_q     <= bomb_x_d;
         bomb_y_q     <= bomb_y_d;
         b_cnt_q      <= b_cnt_d;
         bombs_q      <= bombs_d;
         fuse_q       <= fuse_d;
         level_done_q <= level_done_d;
         death_q      <= death_d;
         f_key_q      <= f_key_d;
      end
   end

   assign char_pos_x = char_x_q;
   assign char_pos_y = char_y_q;
   assign bomb_pos_x = bomb_x_q;
   assign bomb_pos_y = bomb_y_q;
   assign b_cnt      = {2'b00, b_cnt_q};
   assign bombs_left = bombs_q;
   assign level_done = level_done_q;
   assign death      = death_q;

endmodule
